// File: rtl/usart_rx_core_if.sv
// Port bundle between the USART controller and the receive core.
// The controller side is the master; the receive core is the slave.
`timescale 1ns/1ps
interface usart_rx_core_if #(parameter int DATA_WIDTH = 8);
  logic                  enable_i;
  logic                  baud_tick_i;
  logic                  rx_i;
  logic [3:0]            data_bit_num_i;
  logic                  stop_bit_num_i;
  logic                  parity_en_i;
  logic                  parity_odd_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  data_valid_o;
  logic                  frame_err_o;
  logic                  parity_err_o;
  logic                  busy_o;
  logic [2:0]            state_dbg;

  modport master (
    output enable_i, baud_tick_i, rx_i, data_bit_num_i, stop_bit_num_i,
           parity_en_i, parity_odd_i,
    input  data_o, data_valid_o, frame_err_o, parity_err_o, busy_o, state_dbg
  );

  modport slave (
    input  enable_i, baud_tick_i, rx_i, data_bit_num_i, stop_bit_num_i,
           parity_en_i, parity_odd_i,
    output data_o, data_valid_o, frame_err_o, parity_err_o, busy_o, state_dbg
  );
endinterface

// File: rtl/usart_rx_core.sv
// USART receiver: synchronises rx, oversamples each bit at its centre and
// delivers one parallel word per frame with framing/parity error flags.
`timescale 1ns/1ps
module usart_rx_core #(
    parameter int    OVERSAMPLE   = 16,
    parameter int    DATA_WIDTH   = 8,
    parameter string DO_MSB_FIRST = "FALSE"
) (
    input logic           clk_i,
    input logic           s_rst_n_i,
    usart_rx_core_if.slave bus
);

    // Handshake: data_valid_o is a one-clk strobe with no back-pressure; data_o and
    // both error flags are valid with it and hold their value until the next strobe.

    localparam int              OSW       = $clog2(OVERSAMPLE);
    localparam logic [OSW-1:0]  HALF_LAST = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [OSW-1:0]  FULL_LAST = OSW'(OVERSAMPLE - 1);
    localparam logic [3:0]      MAX_BITS  = 4'(DATA_WIDTH);
    localparam bit              MSB_FIRST = (DO_MSB_FIRST == "TRUE");

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP1     = 3'd4,
        STOP2     = 3'd5,
        WAIT_HIGH = 3'd6
    } rx_state_e;

    rx_state_e             state;
    logic                  rx_meta;
    logic                  rx_s;
    logic [OSW-1:0]        os_cnt;
    logic [3:0]            bit_cnt;
    logic [3:0]            n_bits;
    logic                  two_stop;
    logic                  par_en;
    logic                  par_odd;
    logic                  par_acc;
    logic                  par_err;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  frame_err_q;
    logic                  parity_err_q;
    logic                  busy_q;

    always_ff @(posedge clk_i) begin
        if (!s_rst_n_i) begin
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            state        <= IDLE;
            os_cnt       <= '0;
            bit_cnt      <= '0;
            n_bits       <= '0;
            two_stop     <= 1'b0;
            par_en       <= 1'b0;
            par_odd      <= 1'b0;
            par_acc      <= 1'b0;
            par_err      <= 1'b0;
            shreg        <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            rx_meta <= bus.rx_i;
            rx_s    <= rx_meta;
            valid_q <= 1'b0;

            if (state != IDLE && !bus.enable_i) begin
                state  <= IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.enable_i && !rx_s) begin
                            state    <= START;
                            busy_q   <= 1'b1;
                            os_cnt   <= '0;
                            bit_cnt  <= '0;
                            shreg    <= '0;
                            par_acc  <= 1'b0;
                            par_err  <= 1'b0;
                            two_stop <= bus.stop_bit_num_i;
                            par_en   <= bus.parity_en_i;
                            par_odd  <= bus.parity_odd_i;
                            n_bits   <= (bus.data_bit_num_i < 4'd5)    ? 4'd5 :
                                        (bus.data_bit_num_i > MAX_BITS) ? MAX_BITS :
                                        bus.data_bit_num_i;
                        end
                    end

                    // Half a bit in, re-check the line to reject glitches.
                    START: begin
                        if (bus.baud_tick_i) begin
                            if (os_cnt == HALF_LAST) begin
                                os_cnt <= '0;
                                if (rx_s) begin
                                    state  <= IDLE;
                                    busy_q <= 1'b0;
                                end else begin
                                    state <= DATA;
                                end
                            end else begin
                                os_cnt <= os_cnt + 1'b1;
                            end
                        end
                    end

                    DATA: begin
                        if (bus.baud_tick_i) begin
                            if (os_cnt == FULL_LAST) begin
                                os_cnt  <= '0;
                                bit_cnt <= bit_cnt + 4'd1;
                                par_acc <= par_acc ^ rx_s;
                                if (MSB_FIRST) shreg <= {shreg[DATA_WIDTH-2:0], rx_s};
                                else           shreg <= shreg | (DATA_WIDTH'(rx_s) << bit_cnt);
                                if (bit_cnt == n_bits - 4'd1) state <= par_en ? PARITY : STOP1;
                            end else begin
                                os_cnt <= os_cnt + 1'b1;
                            end
                        end
                    end

                    PARITY: begin
                        if (bus.baud_tick_i) begin
                            if (os_cnt == FULL_LAST) begin
                                os_cnt  <= '0;
                                par_err <= ((par_acc ^ rx_s) != par_odd);
                                state   <= STOP1;
                            end else begin
                                os_cnt <= os_cnt + 1'b1;
                            end
                        end
                    end

                    // Frame completes at the stop sample point, leaving half a bit of
                    // slack before a back-to-back start edge can arrive.
                    STOP1, STOP2: begin
                        if (bus.baud_tick_i) begin
                            if (os_cnt == FULL_LAST) begin
                                os_cnt <= '0;
                                if (state == STOP1 && rx_s && two_stop) begin
                                    state <= STOP2;
                                end else begin
                                    data_q       <= shreg;
                                    frame_err_q  <= !rx_s;
                                    parity_err_q <= par_err;
                                    valid_q      <= 1'b1;
                                    state        <= rx_s ? IDLE : WAIT_HIGH;
                                    busy_q       <= !rx_s;
                                end
                            end else begin
                                os_cnt <= os_cnt + 1'b1;
                            end
                        end
                    end

                    WAIT_HIGH: begin
                        if (rx_s) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end

                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.data_o       = data_q;
    assign bus.data_valid_o = valid_q;
    assign bus.frame_err_o  = frame_err_q;
    assign bus.parity_err_o = parity_err_q;
    assign bus.busy_o       = busy_q;
    assign bus.state_dbg    = state;

endmodule

// File: tb/tb_usart_rx_core.sv
// Bench for usart_rx_core: serial frames are built from the frame format rules
// and the expected word/flags are derived from the transmitted content.
`timescale 1ns/1ps
module tb_usart_rx_core;
  localparam int OS       = 16;
  localparam int DW       = 8;
  localparam int DIV      = 4;
  localparam int BIT_CLKS = OS * DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   tick_run = 1'b0;
  int   tick_div = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Expected entries: {frame_err, parity_err, data}
  logic [DW+1:0] exp_q[$];
  // Captured entries: {busy, frame_err, parity_err, data}
  logic [DW+2:0] got_q[$];

  usart_rx_core_if #(.DATA_WIDTH(DW)) bus ();

  usart_rx_core #(.OVERSAMPLE(OS), .DATA_WIDTH(DW), .DO_MSB_FIRST("FALSE")) dut (
    .clk_i    (clk),
    .s_rst_n_i(rst_n),
    .bus      (bus)
  );

  // clock / reset / tick
  always #5 clk = ~clk;

  initial begin
    bus.baud_tick_i = 1'b0;
    forever begin
      @(negedge clk);
      bus.baud_tick_i = tick_run && (tick_div == DIV - 1);
      tick_div = (tick_div + 1) % DIV;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) begin
    if (rst_n && bus.data_valid_o)
      got_q.push_back({bus.busy_o, bus.frame_err_o, bus.parity_err_o, bus.data_o});
  end

  // driver plus reference model: expected result follows from the frame content
  task automatic send_frame(input logic [7:0] val, input logic [3:0] nb_pin, input bit two_stop,
                            input bit par_en, input bit par_odd, input bit par_flip,
                            input bit stop2_low, input bit expect_out, input int abort_bit);
    int         nb;
    logic [7:0] masked;
    logic [7:0] mask;
    bit         pbit;
    nb     = (int'(nb_pin) < 5) ? 5 : (int'(nb_pin) > DW) ? DW : int'(nb_pin);
    mask   = 8'((1 << nb) - 1);
    masked = val & mask;
    pbit   = (^masked) ^ par_odd ^ par_flip;
    if (expect_out && abort_bit < 0)
      exp_q.push_back({two_stop & stop2_low, par_en & par_flip, masked});

    @(negedge clk);
    bus.data_bit_num_i = nb_pin;
    bus.stop_bit_num_i = two_stop;
    bus.parity_en_i    = par_en;
    bus.parity_odd_i   = par_odd;
    bus.rx_i           = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    // format pins may change freely once the frame has started
    bus.data_bit_num_i = 4'($urandom_range(0, 15));
    bus.stop_bit_num_i = 1'($urandom_range(0, 1));
    bus.parity_en_i    = 1'($urandom_range(0, 1));
    bus.parity_odd_i   = 1'($urandom_range(0, 1));
    for (int i = 0; i < nb; i++) begin
      bus.rx_i = masked[i];
      if (i == abort_bit) begin
        repeat (BIT_CLKS / 2) @(negedge clk);
        bus.enable_i = 1'b0;
        repeat (BIT_CLKS / 2) @(negedge clk);
      end else begin
        repeat (BIT_CLKS) @(negedge clk);
      end
    end
    if (par_en) begin
      bus.rx_i = pbit;
      repeat (BIT_CLKS) @(negedge clk);
    end
    bus.rx_i = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    if (two_stop) begin
      bus.rx_i = !stop2_low;
      repeat (BIT_CLKS) @(negedge clk);
    end
    if (abort_bit >= 0) bus.enable_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if (bus.data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", bus.data_o); end
    n_checks++; if (bus.data_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.data_valid_o); end
    n_checks++; if (bus.frame_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", bus.frame_err_o); end
    n_checks++; if (bus.parity_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b expected 0", bus.parity_err_o); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_8n1();
    logic [DW+1:0] e;
    logic [DW+2:0] g;
    send_frame(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    for (int i = 0; i < 4 * BIT_CLKS && got_q.size() < exp_q.size(); i++) @(negedge clk);
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL 8n1_count: got %0d pulses expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++; if (g[DW+1:0] !== e) begin n_fail++; $display("FAIL 8n1_word: got %h expected %h", g[DW+1:0], e); end
      n_checks++; if (g[DW+2] !== 1'b0) begin n_fail++; $display("FAIL 8n1_busy_at_valid: got %b expected 0", g[DW+2]); end
    end
    exp_q.delete(); got_q.delete();
    repeat (20) @(negedge clk);
    n_checks++; if (bus.data_o !== 8'hA5) begin n_fail++; $display("FAIL 8n1_hold: got %h expected a5", bus.data_o); end
  endtask

  task automatic test_parity();
    logic [DW+1:0] e;
    logic [DW+2:0] g;
    send_frame(8'h41, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'h41, 4'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    for (int i = 0; i < 4 * BIT_CLKS && got_q.size() < exp_q.size(); i++) @(negedge clk);
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL 7e1_count: got %0d pulses expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++; if (g[DW+1:0] !== e) begin n_fail++; $display("FAIL 7e1_word: got %h expected %h", g[DW+1:0], e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_frame_err();
    logic [DW+1:0] e;
    logic [DW+2:0] g;
    send_frame(8'h3C, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    repeat (3 * BIT_CLKS) @(negedge clk);
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL 8n2_count: got %0d pulses expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++; if (g[DW+1:0] !== e) begin n_fail++; $display("FAIL 8n2_word: got %h expected %h", g[DW+1:0], e); end
      n_checks++; if (g[DW+2] !== 1'b1) begin n_fail++; $display("FAIL 8n2_busy_at_valid: got %b expected 1", g[DW+2]); end
    end
    exp_q.delete(); got_q.delete();
    n_checks++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL wait_high_busy: got %b expected 1", bus.busy_o); end
    bus.rx_i = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL wait_high_release: got %b expected 0", bus.busy_o); end
    send_frame(8'h3C, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    for (int i = 0; i < 4 * BIT_CLKS && got_q.size() < exp_q.size(); i++) @(negedge clk);
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL 8n2_clean_count: got %0d pulses expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++; if (g[DW+1:0] !== e) begin n_fail++; $display("FAIL 8n2_clean_word: got %h expected %h", g[DW+1:0], e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_glitch();
    @(negedge clk);
    bus.rx_i = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    bus.rx_i = 1'b1;
    n_checks++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start: got %b expected 1", bus.busy_o); end
    repeat (BIT_CLKS) @(negedge clk);
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end: got %b expected 0", bus.busy_o); end
    n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL glitch_no_valid: got %0d pulses expected 0", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [DW+1:0] e;
    logic [DW+2:0] g;
    send_frame(8'h00, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'hFF, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'h55, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'h1F, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    for (int i = 0; i < 4 * BIT_CLKS && got_q.size() < exp_q.size(); i++) @(negedge clk);
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d pulses expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++; if (g[DW+1:0] !== e) begin n_fail++; $display("FAIL b2b_word: got %h expected %h", g[DW+1:0], e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random();
    logic [DW+1:0] e;
    logic [DW+2:0] g;
    for (int k = 0; k < 12; k++) begin
      send_frame(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'b0, 1'b1, -1);
      repeat ($urandom_range(0, 80)) @(negedge clk);
    end
    for (int i = 0; i < 4 * BIT_CLKS && got_q.size() < exp_q.size(); i++) @(negedge clk);
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d pulses expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++; if (g[DW+1:0] !== e) begin n_fail++; $display("FAIL rand_word: got %h expected %h", g[DW+1:0], e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_abort();
    logic [DW+1:0] e;
    logic [DW+2:0] g;
    send_frame(8'h5A, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3);
    repeat (BIT_CLKS) @(negedge clk);
    n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL abort_no_valid: got %0d pulses expected 0", got_q.size()); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", bus.busy_o); end
    got_q.delete();
    send_frame(8'h81, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    for (int i = 0; i < 4 * BIT_CLKS && got_q.size() < exp_q.size(); i++) @(negedge clk);
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL abort_rx_count: got %0d pulses expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++; if (g[DW+1:0] !== e) begin n_fail++; $display("FAIL abort_rx_word: got %h expected %h", g[DW+1:0], e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid();
    fork
      send_frame(8'hFF, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
      begin
        repeat (4 * BIT_CLKS) @(negedge clk);
        n_checks++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_before: got %b expected 1", bus.busy_o); end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.data_o !== 8'h00) begin n_fail++; $display("FAIL rst_mid_data: got %h expected 00", bus.data_o); end
        n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy_o); end
        n_checks++; if (bus.data_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", bus.data_valid_o); end
        rst_n = 1'b1;
      end
    join
    repeat (2 * BIT_CLKS) @(negedge clk);
    n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL rst_mid_no_valid: got %0d pulses expected 0", got_q.size()); end
    got_q.delete();
  endtask

  initial begin
    bus.enable_i       = 1'b0;
    bus.rx_i           = 1'b1;
    bus.data_bit_num_i = 4'd8;
    bus.stop_bit_num_i = 1'b0;
    bus.parity_en_i    = 1'b0;
    bus.parity_odd_i   = 1'b0;
    test_reset();
    tick_run     = 1'b1;
    bus.enable_i = 1'b1;
    repeat (10) @(negedge clk);
    test_8n1();
    test_parity();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_random();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/usart_rx_core.md
Name: usart_rx_core

Overview:
- Self-contained USART receiver that deserialises the asynchronous rx line into parallel data words for the USART controller.
- Functional counterpart of the existing transmit path. It shares the baud generator's tick (run at OVERSAMPLE x baud) and the controller-supplied frame format inputs.
- Contains its own input synchroniser, oversample counter, bit counter, shift register and frame FSM.
- Reports each received word with a one-cycle valid pulse and error flags.

Parameters:
- OVERSAMPLE, 16: baud_tick_i pulses per bit period; even, 4..32.
- DATA_WIDTH, 8: maximum data bits per frame; data_o width.
- DO_MSB_FIRST, "FALSE": "FALSE" means first received bit is the LSB; "TRUE" means first received bit is the MSB.

Ports:
- clk_i  in  1  system clock.
- s_rst_n_i  in  1  synchronous active-low reset.
- enable_i  in  1  receiver enable from controller.
- baud_tick_i  in  1  oversample tick, one clk_i wide.
- rx_i  in  1  asynchronous serial line, idle high.
- data_bit_num_i  in  4  data bits per frame, 5..DATA_WIDTH.
- stop_bit_num_i  in  1  0 = one stop bit, 1 = two stop bits.
- parity_en_i  in  1  parity bit present.
- parity_odd_i  in  1  1 = odd parity, 0 = even parity.
- data_o  out  DATA_WIDTH  received word, right-aligned, unused MSBs 0.
- data_valid_o  out  1  one-cycle pulse, data_o/flags valid.
- frame_err_o  out  1  stop bit sampled low (qualified by data_valid_o).
- parity_err_o  out  1  parity mismatch (qualified by data_valid_o).
- busy_o  out  1  high while not in IDLE.

Behaviour:
- One clock; reset is synchronous and active-low: s_rst_n_i sampled on the clk_i rising edge, 0 = reset.
- Reset values:
  - data_o = 0; data_valid_o = 0; frame_err_o = 0; parity_err_o = 0; busy_o = 0.
  - Synchroniser flops = 1; FSM = IDLE; all counters = 0.
- rx_i passes through a 2-flop synchroniser (rx_s). All decisions use rx_s.
- Oversample counter:
  - Increments only on baud_tick_i.
  - Cleared on every state entry.
  - A "sample point" is the tick on which the counter reaches its target.
- Format latching: data_bit_num_i, stop_bit_num_i, parity_en_i and parity_odd_i are latched on IDLE->START. Later changes do not affect the frame in progress. data_bit_num_i < 5 is treated as 5; > DATA_WIDTH is treated as DATA_WIDTH.
- FSM states:
  - IDLE: if enable_i && rx_s == 0, go to START.
  - START: sample point at OVERSAMPLE/2 ticks (mid start bit). If rx_s == 1 it is a false start: go to IDLE with no output. Otherwise go to DATA.
  - DATA: sample point every OVERSAMPLE ticks. Shift rx_s into the register. Bit counter++. After N bits, go to PARITY if parity enabled, else STOP1.
  - PARITY: sample after OVERSAMPLE ticks. Error if XOR(data bits, parity bit) != parity_odd.
  - STOP1: sample after OVERSAMPLE ticks. rx_s == 0 sets frame error. If two stop bits and no error, go to STOP2; else finish.
  - STOP2: sample after OVERSAMPLE ticks. rx_s == 0 sets frame error. Then finish.
  - Finish: on the clk after the final stop sample point, data_o, frame_err_o and parity_err_o update and data_valid_o = 1 for exactly one clk. Then go to IDLE if rx_s == 1, else WAIT_HIGH.
  - WAIT_HIGH (break or framing error): stay until rx_s == 1, then go to IDLE. No further outputs.
- Output holding: data_o and the flags hold until the next data_valid_o. data_valid_o is emitted even on error; the flags qualify it.
- Bit ordering: with DO_MSB_FIRST = "FALSE", the first bit lands in data_o[0]. Bits above N are 0.
- Returning to IDLE right at the stop sample point gives half a bit of slack for back-to-back frames.
- enable_i deasserted in any non-IDLE state: go to IDLE on the next clk. The frame is discarded with no data_valid_o.
- baud_tick_i absent: the FSM holds state, and the synchroniser keeps running.
- Mid-operation reset: all state and outputs return to their reset values on the next clk edge.
- busy_o = (state != IDLE), registered.

Test Plan:
- 8N1, OVERSAMPLE = 16, tick every 4 clk, send 0xA5 LSB-first -> one data_valid_o pulse; data_o = 0xA5; both error flags 0; busy_o falls at valid.
- 7E1, send 0x41 with correct parity bit 0, then 0x41 with wrong parity bit 1 -> data_o = 0x41 both times; parity_err_o = 0 then 1; frame_err_o = 0.
- 8N2, send 0x3C with the second stop bit low -> data_valid_o pulse with frame_err_o = 1; then FSM waits in WAIT_HIGH until the line returns high; next frame 0x3C is received clean.
- Glitch: rx low for 3 ticks, then high -> false start; no data_valid_o; busy_o back to 0 after the START sample point.
- Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap -> three valid pulses in order, no errors; 5-bit mode frame 0x1F -> data_o = 0x1F.
- Abort and reset: drop enable_i mid-DATA -> no valid pulse; re-enable and send 0x81 -> received. Assert s_rst_n_i mid-frame -> all outputs 0 next clk.
